wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//   Wishbone classic initiator: turns single valid/ready requests from user logic into one
//   bus cycle each and returns the read data or an error as a response. Counterpart to the
//   wbs_* responder ports of the user-area wrapper, for driving Wishbone peripherals from logic.
//   Non-pipelined: at most one outstanding transaction.
// PARAMETERS
//   ADDR_W   32   address width
//   DATA_W   32   data width; must be a multiple of 8
//   SEL_W    DATA_W/8  byte-select width (derived; do not override)
//   TIMEOUT  255  cycles with cyc/stb asserted and no ack/err before abort; range 1..65535
// PORTS
//   wb_clk_i     in   1       clock; all logic on rising edge
//   wb_rst_i     in   1       synchronous reset, active-high
//   req_valid    in   1       request present
//   req_ready    out  1       bridge accepts a request this cycle
//   req_we       in   1       1 = write, 0 = read
//   req_adr      in   ADDR_W  byte address
//   req_dat      in   DATA_W  write data
//   req_sel      in   SEL_W   byte enables
//   rsp_valid    out  1       response present
//   rsp_ready    in   1       consumer takes the response
//   rsp_dat      out  DATA_W  read data (0 for writes and errors)
//   rsp_err      out  1       1 = bus error or timeout
//   wbm_cyc_o    out  1       Wishbone cycle
//   wbm_stb_o    out  1       Wishbone strobe (always equal to wbm_cyc_o)
//   wbm_we_o     out  1       Wishbone write enable
//   wbm_adr_o    out  ADDR_W  Wishbone address
//   wbm_dat_o    out  DATA_W  Wishbone write data
//   wbm_sel_o    out  SEL_W   Wishbone byte select
//   wbm_dat_i    in   DATA_W  Wishbone read data
//   wbm_ack_i    in   1       Wishbone acknowledge
//   wbm_err_i    in   1       Wishbone error
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_dat=0, wbm_cyc_o/stb_o/we_o=0,
//     wbm_adr_o/dat_o/sel_o=0, timeout counter=0. A reset in any state aborts the transfer with no response.
//   FSM IDLE -> BUS -> RESP -> IDLE. All outputs registered. req_ready = (state==IDLE).
//   IDLE: on req_valid at edge N, latch we/adr/dat/sel onto wbm_*; cyc=stb=1 from N+1; counter cleared.
//   BUS: cyc/stb/adr/we/dat/sel stay stable. Each cycle without ack/err increments the counter.
//     err_i=1 at edge M: cyc=stb=0 from M+1; rsp_err=1, rsp_dat=0, rsp_valid=1 from M+1.
//     ack_i=1 (err_i=0) at edge M: cyc=stb=0 from M+1; rsp_err=0; rsp_dat=wbm_dat_i if read, else 0;
//       rsp_valid=1 from M+1. Minimum request-to-response latency is 2 cycles (ack in first BUS cycle).
//     ack and err together: err wins.
//     Counter==TIMEOUT-1 with no ack/err: abort as for err (rsp_err=1, rsp_dat=0), i.e. cyc held
//       for exactly TIMEOUT cycles. ack/err in that same cycle take priority over the timeout.
//   RESP: rsp_valid/rsp_dat/rsp_err hold until rsp_ready=1; at that edge rsp_valid=0 and
//     state=IDLE. No new request is accepted in the same cycle (one idle cycle between transfers).
//   ack_i/err_i seen outside BUS are ignored. wbm_dat_i is sampled only on the ack edge.
//   Counter width = clog2(TIMEOUT+1); it never wraps.
// TESTING
//   Read, ack in first BUS cycle: adr=0x3000_0004, dat_i=0xDEADBEEF -> cyc 1 cycle, rsp_valid 2 cycles
//     after accept, rsp_dat=0xDEADBEEF, rsp_err=0.
//   Write, sel=4'b0011, dat=0x1234_5678, ack after 5 wait cycles -> wbm_* stable for 6 cycles,
//     we=1, rsp_dat=0, rsp_err=0.
//   TIMEOUT=8, no ack -> cyc high exactly 8 cycles, then rsp_err=1, rsp_dat=0; late ack ignored.
//   ack and err in the same cycle -> rsp_err=1. ack in the last timeout cycle -> rsp_err=0.
//   Backpressure: rsp_ready=0 for 10 cycles -> response held stable, req_ready=0 throughout;
//     back-to-back req_valid is accepted only after the response handshake.
//   wb_rst_i pulsed mid-BUS -> next cycle cyc=stb=0, rsp_valid=0, req_ready=1, no response issued.

Source files
------------

// File: rtl/wb_master_bridge.sv
// wb_master_bridge
//   Wishbone classic initiator. Each accepted valid/ready request becomes one
//   bus cycle. The read data, or an error indication, comes back on the
//   response channel. There is at most one transaction in flight.
//
// Ports
//   wb_clk_i, wb_rst_i        clock; synchronous active-high reset
//   req_valid/ready/we/adr/dat/sel
//                             request channel from user logic
//   rsp_valid/ready/dat/err   response channel to user logic
//   wbm_cyc_o..wbm_sel_o      Wishbone initiator outputs (all registered)
//   wbm_dat_i/ack_i/err_i     Wishbone responder returns
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               rvld_q, rvld_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;
  logic               rerr_q, rerr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rvld_d  = rvld_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_BUS;
          ready_d = 1'b0;
          cyc_d   = 1'b1;
          we_d    = req_we;
          adr_d   = req_adr;
          dat_d   = req_dat;
          sel_d   = req_sel;
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        // Priority: err, then ack, then timeout.
        if (wbm_err_i) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
          rdat_d  = '0;
        end else if (wbm_ack_i) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = 1'b0;
          rdat_d  = we_q ? '0 : wbm_dat_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // cnt_q runs 0..TIMEOUT-1, so cyc is high exactly TIMEOUT cycles.
          state_d = S_RESP;
          cyc_d   = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
          rdat_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        // Leaving through IDLE forces one idle cycle between transfers.
        if (rsp_ready) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          rvld_d  = 1'b0;
          rerr_d  = 1'b0;
          rdat_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rvld_q;
  assign rsp_dat   = rdat_q;
  assign rsp_err   = rerr_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge. The bench acts as the Wishbone responder.
// Expected responses are queued at request accept and popped at the
// response handshake.
module tb_wb_master_bridge;
  localparam int AW = 32, DW = 32, SW = 4, TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [SW-1:0] req_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o, dat_i;
  logic [SW-1:0] sel;
  logic          ack, err;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  int n_chk = 0, n_err = 0;
  logic [DW:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ack, 1 err, 2 ack+err together, 3 no reply (timeout)
  task automatic txn(input logic t_we, input logic [AW-1:0] t_adr, input logic [DW-1:0] t_dat,
                     input logic [SW-1:0] t_sel, input int wait_n, input int mode,
                     input logic [DW-1:0] rdat, input int bp, input bit b2b);
    int k;
    logic e_err;
    logic [DW-1:0] e_dat;
    logic [DW:0] ex;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = t_we; req_adr = t_adr; req_dat = t_dat; req_sel = t_sel;
    tick;
    req_valid = 1'b0;
    req_adr = ~t_adr; req_dat = ~t_dat; req_sel = ~t_sel; req_we = ~t_we;
    e_err = (mode != 0);
    e_dat = (e_err || t_we) ? '0 : rdat;
    exp_q.push_back({e_err, e_dat});
    k = 0;
    while (cyc === 1'b1 && k < 100) begin
      chk("stb", stb, 1);
      chk("adr", adr, t_adr);
      chk("we", we, t_we);
      chk("dat_o", dat_o, t_dat);
      chk("sel", sel, t_sel);
      chk("rsp_valid_bus", rsp_valid, 0);
      if (mode != 3 && k == wait_n) begin
        ack = (mode != 1);
        err = (mode != 0);
        dat_i = rdat;
      end
      tick;
      ack = 1'b0; err = 1'b0; dat_i = $urandom;
      k++;
    end
    chk("cyc_cycles", k, (mode == 3) ? TO : wait_n + 1);
    chk("stb_low", stb, 0);
    chk("rsp_valid_up", rsp_valid, 1);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      if (b2b) req_valid = 1'b1;
      if (i == 0) ack = 1'b1;  // stray ack outside BUS must be ignored
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_err", rsp_err, e_err);
      chk("bp_rsp_dat", rsp_dat, e_dat);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_cyc", cyc, 0);
      tick;
      ack = 1'b0;
    end
    rsp_ready = 1'b1;
    ex = exp_q.pop_front();
    chk("rsp_err", rsp_err, ex[DW]);
    chk("rsp_dat", rsp_dat, ex[DW-1:0]);
    tick;
    rsp_ready = 1'b0;
    chk("rsp_valid_clr", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("no_same_cycle_accept", cyc, 0);
  endtask

  task automatic reset_mid_bus;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0100; req_sel = 4'hF;
    tick;
    req_valid = 1'b0;
    chk("rst_pre_cyc", cyc, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_no_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack = 1'b0; err = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rvld", rsp_valid, 0);
    chk("rst_rerr", rsp_err, 0);
    chk("rst_rdat", rsp_dat, 0);
    chk("rst_cyc0", cyc, 0);
    chk("rst_we0", we, 0);
    chk("rst_adr0", adr, 0);
    chk("rst_dat0", dat_o, 0);
    chk("rst_sel0", sel, 0);
    tick;

    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 1'b0);
    txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011, 5, 0, 32'hAAAA_5555, 0, 1'b0);
    txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 3, 32'h1111_2222, 2, 1'b0);
    txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1, 2, 32'h3333_4444, 0, 1'b0);
    txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, TO - 1, 0, 32'hCAFE_F00D, 0, 1'b0);
    txn(1'b1, 32'h3000_002C, 32'h5A5A_A5A5, 4'b1100, 2, 1, 32'h7777_8888, 0, 1'b0);
    txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 0, 32'h0BAD_F00D, 10, 1'b1);
    txn(1'b0, 32'h3000_0034, 32'h0, 4'h1, 0, 0, 32'h0000_00A5, 0, 1'b0);
    reset_mid_bus();
    txn(1'b0, 32'h3000_0038, 32'h0, 4'hF, 3, 0, 32'h1357_9BDF, 0, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
